// File: rtl/md_stall_ctrl_if.sv
// Handshake bundle between the pipeline hazard logic and the HI/LO scheduler.
// The master is the pipeline side; the slave is md_stall_ctrl.
interface md_stall_ctrl_if;
    logic       StartE;
    logic [1:0] OpE;
    logic       MDUseD;
    logic       DataStallD;
    logic       StallF;
    logic       StallD;
    logic       FlushE;
    logic       Busy;
    logic       Done;
    logic [1:0] State;
    logic [3:0] BusyCnt;

    modport master (
        output StartE, OpE, MDUseD, DataStallD,
        input  StallF, StallD, FlushE, Busy, Done, State, BusyCnt
    );

    modport slave (
        input  StartE, OpE, MDUseD, DataStallD,
        output StallF, StallD, FlushE, Busy, Done, State, BusyCnt
    );
endinterface

// File: rtl/md_stall_ctrl.sv
// Multiply/divide busy tracker and F/D stall + D/E bubble controller.
// An MD-touching instruction in D waits until the HI/LO unit commits.
module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            Clk,
    input logic            Reset,
    md_stall_ctrl_if.slave md
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MULT = 2'b01,
        S_DIV  = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       busy;
    logic       md_stall;
    logic       stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (md.StartE) begin
                    if (md.OpE[1]) begin
                        state_nxt = S_DIV;
                        cnt_nxt   = DIV_N;
                    end else begin
                        state_nxt = S_MULT;
                        cnt_nxt   = MULT_N;
                    end
                end else begin
                    cnt_nxt = 4'd0;
                end
            end
            S_MULT, S_DIV: begin
                // A start seen while busy is ignored; the count runs on regardless.
                if (cnt <= 4'd1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign busy = (state == S_MULT) || (state == S_DIV);

    // The StartE term covers the launch cycle, before Busy has risen.
    assign md_stall = md.MDUseD && (busy || md.StartE);
    assign stall    = md_stall || md.DataStallD;

    assign md.Busy    = busy;
    assign md.Done    = busy && (cnt == 4'd1);
    assign md.StallF  = stall;
    assign md.StallD  = stall;
    assign md.FlushE  = stall;
    assign md.State   = state;
    assign md.BusyCnt = cnt;
endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a remaining-cycles model.
module tb_md_stall_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic Clk;
    logic Reset;
    md_stall_ctrl_if ifc ();

    md_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .md    (ifc.slave)
    );

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    // clock / reset
    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    // model: remaining busy cycles and the kind of operation (1 mult, 2 div)
    int rem  = 0;
    int kind = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            rem  = 0;
            kind = 0;
        end else if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) kind = 0;
        end else if (ifc.StartE) begin
            kind = ifc.OpE[1] ? 2 : 1;
            rem  = ifc.OpE[1] ? DIV_N : MULT_N;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // compare process, away from the active edge
    always @(negedge Clk) begin
        if (check_en) begin
            int exp_stall;
            exp_stall = ((ifc.MDUseD && (rem > 0 || ifc.StartE)) || ifc.DataStallD) ? 1 : 0;
            chk("m_busy",    int'(ifc.Busy),    (rem > 0) ? 1 : 0);
            chk("m_done",    int'(ifc.Done),    (rem == 1) ? 1 : 0);
            chk("m_state",   int'(ifc.State),   kind);
            chk("m_busycnt", int'(ifc.BusyCnt), rem);
            chk("m_stallf",  int'(ifc.StallF),  exp_stall);
            chk("m_stalld",  int'(ifc.StallD),  exp_stall);
            chk("m_flushe",  int'(ifc.FlushE),  exp_stall);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit start, input bit [1:0] op, input bit use_d, input bit ds);
        ifc.StartE     = start;
        ifc.OpE        = op;
        ifc.MDUseD     = use_d;
        ifc.DataStallD = ds;
    endtask

    task automatic chk_stall(input string name, input int exp);
        chk({name, "_f"}, int'(ifc.StallF), exp);
        chk({name, "_d"}, int'(ifc.StallD), exp);
        chk({name, "_e"}, int'(ifc.FlushE), exp);
    endtask

    initial begin
        Reset = 1;
        drive(0, 2'b00, 0, 0);
        tick();
        tick();
        Reset = 0;
        check_en = 1;

        // reset in the middle of a divide
        drive(1, 2'b10, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0);
        repeat (4) tick();
        #1;
        chk("div_cnt6", int'(ifc.BusyCnt), 6);
        Reset = 1;
        tick();
        Reset = 0;
        #1;
        chk("rst_state", int'(ifc.State), 0);
        chk("rst_cnt",   int'(ifc.BusyCnt), 0);
        chk("rst_busy",  int'(ifc.Busy), 0);
        chk("rst_done",  int'(ifc.Done), 0);
        ifc.DataStallD = 1;
        #1;
        chk_stall("rst_ds", 1);
        ifc.DataStallD = 0;
        tick();

        // single mult
        drive(1, 2'b00, 0, 0);
        tick();
        drive(0, 2'b00, 0, 0);
        for (int i = 0; i < MULT_N; i++) begin
            #1;
            chk("mult_busy", int'(ifc.Busy), 1);
            chk("mult_cnt",  int'(ifc.BusyCnt), MULT_N - i);
            chk("mult_done", int'(ifc.Done), (i == MULT_N - 1) ? 1 : 0);
            tick();
        end
        #1;
        chk("mult_idle", int'(ifc.State), 0);
        chk("mult_busy_end", int'(ifc.Busy), 0);
        tick();

        // divu with mflo waiting in D
        drive(1, 2'b11, 1, 0);
        #1;
        chk_stall("divu_launch", 1);
        tick();
        ifc.StartE = 0;
        for (int i = 1; i <= DIV_N; i++) begin
            #1;
            chk_stall("divu_hold", 1);
            tick();
        end
        #1;
        chk_stall("divu_release", 0);
        drive(0, 2'b00, 0, 0);
        tick();

        // back-to-back mults: second start sampled at the end of cycle T+6
        drive(1, 2'b00, 0, 0);
        tick();
        ifc.StartE = 0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 6) ifc.StartE = 1;
            else ifc.StartE = 0;
            #1;
            chk("b2b_done", int'(ifc.Done), (c == 5 || c == 11) ? 1 : 0);
            tick();
        end
        drive(0, 2'b00, 0, 0);
        #1;
        chk("b2b_idle", int'(ifc.Busy), 0);
        tick();

        // start while busy is ignored
        drive(1, 2'b00, 0, 0);
        tick();
        ifc.StartE = 0;
        repeat (2) tick();
        #1;
        chk("ign_cnt3", int'(ifc.BusyCnt), 3);
        drive(1, 2'b10, 0, 0);
        #1;
        chk_stall("ign_nostall", 0);
        tick();
        ifc.StartE = 0;
        #1;
        chk("ign_cnt2",  int'(ifc.BusyCnt), 2);
        chk("ign_state", int'(ifc.State), 1);
        tick();
        #1;
        chk("ign_cnt1", int'(ifc.BusyCnt), 1);
        chk("ign_done", int'(ifc.Done), 1);
        tick();
        #1;
        chk("ign_cnt0",  int'(ifc.BusyCnt), 0);
        chk("ign_state0", int'(ifc.State), 0);
        tick();

        // data stall alone while busy
        drive(1, 2'b00, 0, 0);
        tick();
        drive(0, 2'b00, 0, 1);
        #1;
        chk_stall("ds_busy", 1);
        chk("ds_cnt5", int'(ifc.BusyCnt), 5);
        tick();
        #1;
        chk("ds_cnt4", int'(ifc.BusyCnt), 4);
        ifc.DataStallD = 0;
        #1;
        chk_stall("ds_off", 0);
        repeat (5) tick();

        // randomized stimulus, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
            tick();
        end
        Reset = 0;
        drive(0, 2'b00, 0, 0);
        tick();
        @(negedge Clk);
        check_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
